// File: rtl/pong_pkg.sv
// Shared constants for the Pong game-flow controller: state encoding and score width.
package pong_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SERVE     = 3'd1;
  localparam logic [2:0] ST_PLAY      = 3'd2;
  localparam logic [2:0] ST_POINT     = 3'd3;
  localparam logic [2:0] ST_GAME_OVER = 3'd4;

  localparam int SCORE_W = 16;

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Bundle between the game controller and its surroundings (ball datapath, display, score counter).
// master = the controller side, slave = the datapath/display side.
interface pong_game_ctrl_if;
  import pong_pkg::*;

  logic               frame_tick;
  logic               start_btn;
  logic               miss_left;
  logic               miss_right;
  logic               ball_reset;
  logic               play_en;
  logic               serve_dir;
  logic [SCORE_W-1:0] score1;
  logic [SCORE_W-1:0] score2;
  logic               game_over;
  logic               winner;

  modport master (
    input  frame_tick, start_btn, miss_left, miss_right,
    output ball_reset, play_en, serve_dir, score1, score2, game_over, winner
  );

  modport slave (
    output frame_tick, start_btn, miss_left, miss_right,
    input  ball_reset, play_en, serve_dir, score1, score2, game_over, winner
  );

endinterface

// File: rtl/btn_debounce.sv
// Raw push-button conditioner: 2-flop synchroniser, stable-level debounce over DB_CYCLES
// clocks, and a 1-cycle pulse on each debounced rising edge.
module btn_debounce #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_q;
  logic [CW-1:0] cnt;

  // The debounced level only flips after the synchronised input has disagreed with it
  // for DB_CYCLES consecutive clocks; any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_q <= level;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign pulse = level & ~level_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game-flow sequencer (IDLE/SERVE/PLAY/POINT/GAME_OVER) owning both scores.
// Build option PONG_AUTO_SERVE_EN: POINT re-serves automatically instead of waiting for start.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = 11,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int DB_CYCLES    = 1000000
) (
  input logic              clk,
  input logic              rst_n,
  pong_game_ctrl_if.master bus
);

  localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);
  localparam logic [7:0]         SERVE_CNT = 8'(SERVE_FRAMES);
  localparam logic [7:0]         POINT_CNT = 8'(POINT_FRAMES);

  logic               start_p;
  logic [2:0]         state, state_nxt;
  logic [7:0]         frame_cnt;
  logic [SCORE_W-1:0] score1, score1_nxt;
  logic [SCORE_W-1:0] score2, score2_nxt;
  logic               serve_dir, serve_dir_nxt;
  logic               winner, winner_nxt;
  logic               ball_reset, play_en, game_over;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_start_db (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (bus.start_btn),
    .pulse (start_p)
  );

  always_comb begin
    state_nxt     = state;
    score1_nxt    = score1;
    score2_nxt    = score2;
    serve_dir_nxt = serve_dir;
    winner_nxt    = winner;
    case (state)
      ST_IDLE: begin
        if (start_p) begin
          state_nxt  = ST_SERVE;
          score1_nxt = '0;
          score2_nxt = '0;
        end
      end
      ST_SERVE: begin
        if (frame_cnt >= SERVE_CNT) state_nxt = ST_PLAY;
      end
      ST_PLAY: begin
        // P1 wins a same-cycle tie; the ball is then served toward the player who lost the point.
        if (bus.miss_right) begin
          if (score1 < WIN_VAL) score1_nxt = score1 + SCORE_W'(1);
          serve_dir_nxt = 1'b1;
          state_nxt     = ST_POINT;
        end else if (bus.miss_left) begin
          if (score2 < WIN_VAL) score2_nxt = score2 + SCORE_W'(1);
          serve_dir_nxt = 1'b0;
          state_nxt     = ST_POINT;
        end
      end
      ST_POINT: begin
        if (frame_cnt >= POINT_CNT) begin
          if (score1 == WIN_VAL) begin
            state_nxt  = ST_GAME_OVER;
            winner_nxt = 1'b0;
          end else if (score2 == WIN_VAL) begin
            state_nxt  = ST_GAME_OVER;
            winner_nxt = 1'b1;
          end else begin
`ifdef PONG_AUTO_SERVE_EN
            state_nxt = ST_SERVE;
`else
            if (start_p) state_nxt = ST_SERVE;
`endif
          end
        end
      end
      ST_GAME_OVER: begin
        if (start_p) begin
          state_nxt     = ST_SERVE;
          score1_nxt    = '0;
          score2_nxt    = '0;
          serve_dir_nxt = 1'b0;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land on the same edge as the transition.
  // The frame counter saturates so a held POINT state cannot wrap back below the threshold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      frame_cnt  <= '0;
      score1     <= '0;
      score2     <= '0;
      serve_dir  <= 1'b0;
      winner     <= 1'b0;
      ball_reset <= 1'b1;
      play_en    <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      state     <= state_nxt;
      score1    <= score1_nxt;
      score2    <= score2_nxt;
      serve_dir <= serve_dir_nxt;
      winner    <= winner_nxt;
      if (state_nxt != state) begin
        frame_cnt <= '0;
      end else if (bus.frame_tick && frame_cnt != 8'hFF) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
      ball_reset <= (state_nxt != ST_PLAY);
      play_en    <= (state_nxt == ST_SERVE) || (state_nxt == ST_PLAY);
      game_over  <= (state_nxt == ST_GAME_OVER);
    end
  end

  assign bus.ball_reset = ball_reset;
  assign bus.play_en    = play_en;
  assign bus.serve_dir  = serve_dir;
  assign bus.score1     = score1;
  assign bus.score2     = score2;
  assign bus.game_over  = game_over;
  assign bus.winner     = winner;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with small parameters (DB=4, SERVE=2, POINT=2, WIN=3).
// Expectations for the POINT re-serve follow PONG_AUTO_SERVE_EN as compiled.
module tb_pong_game_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  pong_game_ctrl_if bus();

  pong_game_ctrl #(
    .WIN_SCORE    (3),
    .SERVE_FRAMES (2),
    .POINT_FRAMES (2),
    .DB_CYCLES    (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic press_start();
    bus.start_btn = 1'b1;
    repeat (6) @(negedge clk);
    bus.start_btn = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic tick_frames(input int n);
    for (int i = 0; i < n; i++) begin
      bus.frame_tick = 1'b1;
      @(negedge clk);
      bus.frame_tick = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic miss(input logic l, input logic r);
    bus.miss_left  = l;
    bus.miss_right = r;
    @(negedge clk);
    bus.miss_left  = 1'b0;
    bus.miss_right = 1'b0;
    @(negedge clk);
  endtask

  // From POINT (not winning) back to PLAY, whichever re-serve policy is compiled in.
  task automatic point_to_play();
    tick_frames(2);
`ifndef PONG_AUTO_SERVE_EN
    press_start();
`endif
    tick_frames(2);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.ball_reset, bus.play_en, bus.serve_dir, bus.game_over, bus.winner} !== 5'b10000) begin
      failures++;
      $display("[TB] FAIL reset_flags: got %b expected 10000",
               {bus.ball_reset, bus.play_en, bus.serve_dir, bus.game_over, bus.winner});
    end
    checks++;
    if (bus.score1 !== 16'd0 || bus.score2 !== 16'd0) begin
      failures++;
      $display("[TB] FAIL reset_scores: got %0d/%0d expected 0/0", bus.score1, bus.score2);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_start_serve();
    press_start();
    checks++;
    if ({bus.ball_reset, bus.play_en} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL serve_entry: got %b expected 11", {bus.ball_reset, bus.play_en});
    end
    tick_frames(1);
    checks++;
    if ({bus.ball_reset, bus.play_en} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL serve_hold_1frame: got %b expected 11", {bus.ball_reset, bus.play_en});
    end
    tick_frames(1);
    checks++;
    if ({bus.ball_reset, bus.play_en} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL play_entry: got %b expected 01", {bus.ball_reset, bus.play_en});
    end
  endtask

  task automatic test_point();
    miss(1'b0, 1'b1);
    checks++;
    if (bus.score1 !== 16'd1 || bus.score2 !== 16'd0 || bus.serve_dir !== 1'b1) begin
      failures++;
      $display("[TB] FAIL point_p1: got s1=%0d s2=%0d dir=%b expected 1 0 1",
               bus.score1, bus.score2, bus.serve_dir);
    end
    checks++;
    if ({bus.ball_reset, bus.play_en} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL point_flags: got %b expected 10", {bus.ball_reset, bus.play_en});
    end
    press_start();
    checks++;
    if ({bus.ball_reset, bus.play_en} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL point_early_start: got %b expected 10", {bus.ball_reset, bus.play_en});
    end
    tick_frames(2);
`ifdef PONG_AUTO_SERVE_EN
    checks++;
    if ({bus.ball_reset, bus.play_en} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL auto_serve: got %b expected 11", {bus.ball_reset, bus.play_en});
    end
`else
    repeat (5) @(negedge clk);
    checks++;
    if ({bus.ball_reset, bus.play_en} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL point_hold: got %b expected 10", {bus.ball_reset, bus.play_en});
    end
    press_start();
    checks++;
    if ({bus.ball_reset, bus.play_en} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL manual_serve: got %b expected 11", {bus.ball_reset, bus.play_en});
    end
`endif
    tick_frames(2);
    checks++;
    if ({bus.ball_reset, bus.play_en} !== 2'b01) begin
      failures++;
      $display("[TB] FAIL replay: got %b expected 01", {bus.ball_reset, bus.play_en});
    end
  endtask

  task automatic test_simultaneous();
    miss(1'b1, 1'b1);
    checks++;
    if (bus.score1 !== 16'd2 || bus.score2 !== 16'd0 || bus.serve_dir !== 1'b1) begin
      failures++;
      $display("[TB] FAIL simultaneous_miss: got s1=%0d s2=%0d dir=%b expected 2 0 1",
               bus.score1, bus.score2, bus.serve_dir);
    end
    point_to_play();
  endtask

  task automatic test_game_over();
    miss(1'b1, 1'b0);
    checks++;
    if (bus.score2 !== 16'd1 || bus.serve_dir !== 1'b0) begin
      failures++;
      $display("[TB] FAIL p2_point1: got s2=%0d dir=%b expected 1 0", bus.score2, bus.serve_dir);
    end
    point_to_play();
    miss(1'b1, 1'b0);
    point_to_play();
    miss(1'b1, 1'b0);
    checks++;
    if (bus.score2 !== 16'd3 || bus.game_over !== 1'b0) begin
      failures++;
      $display("[TB] FAIL p2_point3: got s2=%0d go=%b expected 3 0", bus.score2, bus.game_over);
    end
    tick_frames(2);
    checks++;
    if ({bus.game_over, bus.winner, bus.ball_reset, bus.play_en} !== 4'b1110) begin
      failures++;
      $display("[TB] FAIL game_over_entry: got %b expected 1110",
               {bus.game_over, bus.winner, bus.ball_reset, bus.play_en});
    end
    miss(1'b0, 1'b1);
    miss(1'b1, 1'b0);
    checks++;
    if (bus.score1 !== 16'd2 || bus.score2 !== 16'd3 || bus.game_over !== 1'b1) begin
      failures++;
      $display("[TB] FAIL game_over_frozen: got s1=%0d s2=%0d go=%b expected 2 3 1",
               bus.score1, bus.score2, bus.game_over);
    end
    press_start();
    checks++;
    if (bus.score1 !== 16'd0 || bus.score2 !== 16'd0 || bus.serve_dir !== 1'b0 || bus.game_over !== 1'b0) begin
      failures++;
      $display("[TB] FAIL restart: got s1=%0d s2=%0d dir=%b go=%b expected 0 0 0 0",
               bus.score1, bus.score2, bus.serve_dir, bus.game_over);
    end
    checks++;
    if ({bus.ball_reset, bus.play_en} !== 2'b11) begin
      failures++;
      $display("[TB] FAIL restart_serve: got %b expected 11", {bus.ball_reset, bus.play_en});
    end
  endtask

  task automatic test_glitch_and_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.start_btn = 1'b1;
    repeat (2) @(negedge clk);
    bus.start_btn = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if ({bus.ball_reset, bus.play_en} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL glitch_ignored: got %b expected 10", {bus.ball_reset, bus.play_en});
    end
    press_start();
    tick_frames(2);
    miss(1'b0, 1'b1);
    point_to_play();
    checks++;
    if ({bus.ball_reset, bus.play_en} !== 2'b01 || bus.score1 !== 16'd1) begin
      failures++;
      $display("[TB] FAIL pre_reset_play: got flags=%b s1=%0d expected 01 1",
               {bus.ball_reset, bus.play_en}, bus.score1);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.ball_reset, bus.play_en, bus.serve_dir, bus.game_over, bus.winner} !== 5'b10000 ||
        bus.score1 !== 16'd0 || bus.score2 !== 16'd0) begin
      failures++;
      $display("[TB] FAIL midgame_reset: got flags=%b s1=%0d s2=%0d expected 10000 0 0",
               {bus.ball_reset, bus.play_en, bus.serve_dir, bus.game_over, bus.winner},
               bus.score1, bus.score2);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    bus.start_btn  = 1'b0;
    bus.miss_left  = 1'b0;
    bus.miss_right = 1'b0;
    @(negedge clk);
    test_reset();
    test_start_serve();
    test_point();
    test_simultaneous();
    test_game_over();
    test_glitch_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
